// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - in-order pipeline hazard unit: load-use stall, forwarding selects, stage enables
// Optional late store-data forwarding from a load at Mn is built when HDU_STORE_FWD_EN is defined.
module hazard_scoreboard_unit #(
  parameter int MEM_STAGES = 1,
  parameter int RA_W       = 5,
  parameter int FWD_W      = $clog2(MEM_STAGES + 3)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Branch_ID,
  input  logic             rs1use_ID,
  input  logic             rs2use_ID,
  input  logic [1:0]       hazard_optype_ID,
  input  logic [RA_W-1:0]  rs1_ID,
  input  logic [RA_W-1:0]  rs2_ID,
  input  logic [RA_W-1:0]  rd_ID,
  input  logic             mem_busy,
  output logic             PC_EN_IF,
  output logic             reg_FD_EN,
  output logic             reg_FD_stall,
  output logic             reg_FD_flush,
  output logic             reg_DE_EN,
  output logic             reg_DE_flush,
  output logic             reg_EM_EN,
  output logic             reg_MW_EN,
  output logic [FWD_W-1:0] forward_ctrl_A,
  output logic [FWD_W-1:0] forward_ctrl_B,
  output logic             forward_ctrl_ls
);

  localparam int L = MEM_STAGES + 1;
  localparam int W = MEM_STAGES + 2;
  localparam logic [1:0]       OP_ALU  = 2'b01;
  localparam logic [1:0]       OP_LOAD = 2'b10;
  localparam logic [FWD_W-1:0] L_SEL   = FWD_W'(L);

`ifdef HDU_STORE_FWD_EN
  localparam logic [1:0]       OP_STORE = 2'b11;
  localparam logic [FWD_W-1:0] LM1_SEL  = FWD_W'(L - 1);
  typedef struct packed {
    logic [1:0]      op;
    logic [RA_W-1:0] rd;
    logic            ls;
  } entry_t;
`else
  typedef struct packed {
    logic [1:0]      op;
    logic [RA_W-1:0] rd;
  } entry_t;
`endif

  entry_t r_trk [1:W];

  logic             w_hit_a, w_hit_b, w_ld_a, w_ld_b;
  logic [FWD_W-1:0] w_k_a, w_k_b;
  logic             w_early_a, w_early_b, w_lu_a, w_lu_b;
  logic             w_st_fwd, w_stall;
  entry_t           w_id_entry;

  // Scan oldest to youngest so the youngest matching writer overwrites older hits.
  always_comb begin
    w_hit_a = 1'b0;
    w_hit_b = 1'b0;
    w_ld_a  = 1'b0;
    w_ld_b  = 1'b0;
    w_k_a   = '0;
    w_k_b   = '0;
    for (int k = W; k >= 1; k--) begin
      if ((r_trk[k].op == OP_ALU || r_trk[k].op == OP_LOAD) && r_trk[k].rd != '0) begin
        if (r_trk[k].rd == rs1_ID) begin
          w_hit_a = 1'b1;
          w_k_a   = FWD_W'(k);
          w_ld_a  = (r_trk[k].op == OP_LOAD);
        end
        if (r_trk[k].rd == rs2_ID) begin
          w_hit_b = 1'b1;
          w_k_b   = FWD_W'(k);
          w_ld_b  = (r_trk[k].op == OP_LOAD);
        end
      end
    end
  end

  assign w_early_a = w_ld_a & (w_k_a < L_SEL);
  assign w_early_b = w_ld_b & (w_k_b < L_SEL);
  assign w_lu_a    = rs1use_ID & w_hit_a & w_early_a;
  assign w_lu_b    = rs2use_ID & w_hit_b & w_early_b;

`ifdef HDU_STORE_FWD_EN
  // A store whose data comes from a load one stage short of Mn picks it up in EX instead of stalling.
  assign w_st_fwd   = (hazard_optype_ID == OP_STORE) & w_lu_b & (w_k_b == LM1_SEL) & ~w_lu_a;
  assign w_id_entry = '{op: hazard_optype_ID, rd: rd_ID, ls: w_st_fwd};
  assign forward_ctrl_ls = r_trk[1].ls;
`else
  assign w_st_fwd   = 1'b0;
  assign w_id_entry = '{op: hazard_optype_ID, rd: rd_ID};
  assign forward_ctrl_ls = 1'b0;
`endif

  assign w_stall = w_lu_a | (w_lu_b & ~w_st_fwd);

  assign forward_ctrl_A = (rs1use_ID & w_hit_a & ~w_early_a) ? w_k_a : '0;
  assign forward_ctrl_B = (rs2use_ID & w_hit_b & ~w_early_b) ? w_k_b : '0;

  // Freeze dominates: nothing advances, nothing is squashed.
  assign PC_EN_IF     = ~mem_busy & ~w_stall;
  assign reg_FD_EN    = ~mem_busy;
  assign reg_DE_EN    = ~mem_busy;
  assign reg_EM_EN    = ~mem_busy;
  assign reg_MW_EN    = ~mem_busy;
  assign reg_FD_stall = ~mem_busy & w_stall;
  assign reg_DE_flush = ~mem_busy & w_stall;
  assign reg_FD_flush = ~mem_busy & ~w_stall & Branch_ID;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= W; k++) r_trk[k] <= '0;
    end else if (!mem_busy) begin
      for (int k = W; k >= 2; k--) r_trk[k] <= r_trk[k-1];
      r_trk[1] <= w_stall ? entry_t'('0) : w_id_entry;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - directed and random checks of hazard_scoreboard_unit against a stage-list model
module tb_hazard_scoreboard_unit;

  localparam int MS0 = 1;
  localparam int MS1 = 3;
  localparam int FW0 = $clog2(MS0 + 3);
  localparam int FW1 = $clog2(MS1 + 3);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic br = 1'b0, u1 = 1'b0, u2 = 1'b0, busy = 1'b0;
  logic [1:0] op = 2'b00;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;

  logic pc0, fden0, fdst0, fdfl0, deen0, defl0, em0, mw0, ls0;
  logic pc1, fden1, fdst1, fdfl1, deen1, defl1, em1, mw1, ls1;
  logic [FW0-1:0] fa0, fb0;
  logic [FW1-1:0] fa1, fb1;
  logic [14:0] o0, o1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.MEM_STAGES(MS0), .RA_W(5)) u_dut0 (
    .clk(clk), .rst(rst), .Branch_ID(br), .rs1use_ID(u1), .rs2use_ID(u2),
    .hazard_optype_ID(op), .rs1_ID(rs1), .rs2_ID(rs2), .rd_ID(rd), .mem_busy(busy),
    .PC_EN_IF(pc0), .reg_FD_EN(fden0), .reg_FD_stall(fdst0), .reg_FD_flush(fdfl0),
    .reg_DE_EN(deen0), .reg_DE_flush(defl0), .reg_EM_EN(em0), .reg_MW_EN(mw0),
    .forward_ctrl_A(fa0), .forward_ctrl_B(fb0), .forward_ctrl_ls(ls0));

  hazard_scoreboard_unit #(.MEM_STAGES(MS1), .RA_W(5)) u_dut1 (
    .clk(clk), .rst(rst), .Branch_ID(br), .rs1use_ID(u1), .rs2use_ID(u2),
    .hazard_optype_ID(op), .rs1_ID(rs1), .rs2_ID(rs2), .rd_ID(rd), .mem_busy(busy),
    .PC_EN_IF(pc1), .reg_FD_EN(fden1), .reg_FD_stall(fdst1), .reg_FD_flush(fdfl1),
    .reg_DE_EN(deen1), .reg_DE_flush(defl1), .reg_EM_EN(em1), .reg_MW_EN(mw1),
    .forward_ctrl_A(fa1), .forward_ctrl_B(fb1), .forward_ctrl_ls(ls1));

  assign o0 = {pc0, fden0, fdst0, fdfl0, deen0, defl0, em0, mw0, 3'(fa0), 3'(fb0), ls0};
  assign o1 = {pc1, fden1, fdst1, fdfl1, deen1, defl1, em1, mw1, 3'(fa1), 3'(fb1), ls1};

  // Model: per instance, list of instructions by pipeline position (1 = EX ... MS+2 = WB).
  int m_op [0:1][1:8];
  int m_rd [0:1][1:8];
  int m_ls [0:1][1:8];

  typedef struct {
    int pc, fden, fdst, fdfl, deen, defl, em, mw, fa, fb, ls, stall, stfwd;
  } exp_t;

  function automatic int ms_of(input int d);
    return (d == 0) ? MS0 : MS1;
  endfunction

  function automatic void youngest(input int d, input int rs, output int kk, output bit ld);
    kk = 0;
    ld = 1'b0;
    for (int k = 1; k <= ms_of(d) + 2; k++) begin
      if (kk == 0 && (m_op[d][k] == 1 || m_op[d][k] == 2) && m_rd[d][k] != 0 && m_rd[d][k] == rs) begin
        kk = k;
        ld = (m_op[d][k] == 2);
      end
    end
  endfunction

  function automatic exp_t model_eval(input int d);
    exp_t e;
    int ka, kb, lstage;
    bit la, lb, ua, ub;
    lstage = ms_of(d) + 1;
    youngest(d, int'(rs1), ka, la);
    youngest(d, int'(rs2), kb, lb);
    ua = u1 && ka > 0 && la && ka < lstage;
    ub = u2 && kb > 0 && lb && kb < lstage;
    e.stfwd = 0;
`ifdef HDU_STORE_FWD_EN
    if (op == 2'b11 && ub && kb == lstage - 1 && !ua) e.stfwd = 1;
`endif
    e.stall = (ua || (ub && e.stfwd == 0)) ? 1 : 0;
    e.fa    = (u1 && ka > 0 && !(la && ka < lstage)) ? ka : 0;
    e.fb    = (u2 && kb > 0 && !(lb && kb < lstage)) ? kb : 0;
    e.ls    = m_ls[d][1];
    e.fden  = busy ? 0 : 1;
    e.deen  = e.fden;
    e.em    = e.fden;
    e.mw    = e.fden;
    e.pc    = (busy || e.stall != 0) ? 0 : 1;
    e.fdst  = (!busy && e.stall != 0) ? 1 : 0;
    e.defl  = e.fdst;
    e.fdfl  = (br && !busy && e.stall == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int k = 1; k <= 8; k++) begin
        m_op[d][k] = 0;
        m_rd[d][k] = 0;
        m_ls[d][k] = 0;
      end
  endtask

  task automatic model_step();
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      e = model_eval(d);
      if (!busy) begin
        for (int k = ms_of(d) + 2; k >= 2; k--) begin
          m_op[d][k] = m_op[d][k-1];
          m_rd[d][k] = m_rd[d][k-1];
          m_ls[d][k] = m_ls[d][k-1];
        end
        m_op[d][1] = e.stall ? 0 : int'(op);
        m_rd[d][1] = e.stall ? 0 : int'(rd);
        m_ls[d][1] = e.stall ? 0 : e.stfwd;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input int expv);
    checks++;
    assert (obs === 8'(expv)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    exp_t e;
    logic [14:0] o;
    string p;
    for (int d = 0; d < 2; d++) begin
      e = model_eval(d);
      o = (d == 0) ? o0 : o1;
      p = (d == 0) ? "m1" : "m3";
      chk({p, "_pc_en"},    8'(o[14]),  e.pc);
      chk({p, "_fd_en"},    8'(o[13]),  e.fden);
      chk({p, "_fd_stall"}, 8'(o[12]),  e.fdst);
      chk({p, "_fd_flush"}, 8'(o[11]),  e.fdfl);
      chk({p, "_de_en"},    8'(o[10]),  e.deen);
      chk({p, "_de_flush"}, 8'(o[9]),   e.defl);
      chk({p, "_em_en"},    8'(o[8]),   e.em);
      chk({p, "_mw_en"},    8'(o[7]),   e.mw);
      chk({p, "_fwd_a"},    8'(o[6:4]), e.fa);
      chk({p, "_fwd_b"},    8'(o[3:1]), e.fb);
      chk({p, "_fwd_ls"},   8'(o[0]),   e.ls);
    end
  endtask

  task automatic drive(input int t_op, input int t_rd, input int t_rs1, input int t_rs2,
                       input int t_u1, input int t_u2, input int t_br, input int t_busy);
    op   = 2'(t_op);
    rd   = 5'(t_rd);
    rs1  = 5'(t_rs1);
    rs2  = 5'(t_rs2);
    u1   = (t_u1 != 0);
    u2   = (t_u2 != 0);
    br   = (t_br != 0);
    busy = (t_busy != 0);
  endtask

  task automatic settle();
    #4;
    check_all();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_all();
    chk("reset_pc_en", 8'(pc0), 1);
    chk("reset_fwd_a", 8'(fa0), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ALU forward, then one stage older
    drive(1, 5, 0, 0, 0, 0, 0, 0); settle(); advance();
    drive(0, 0, 5, 0, 1, 0, 1, 0); settle();
    chk("alu_fwd_ex", 8'(fa0), 1);
    chk("alu_fwd_ex_nostall", 8'(pc0), 1);
    chk("branch_flush", 8'(fdfl0), 1);
    advance();
    drive(0, 0, 5, 0, 1, 0, 0, 0); settle();
    chk("alu_fwd_m1", 8'(fa0), 2);
    advance();

    // Load-use: 1 cycle on MEM_STAGES=1, 3 cycles on MEM_STAGES=3
    drive(2, 6, 0, 0, 0, 0, 0, 0); settle(); advance();
    drive(0, 0, 0, 6, 0, 1, 1, 0); settle();
    chk("lu_pc_en", 8'(pc0), 0);
    chk("lu_de_flush", 8'(defl1), 1);
    chk("lu_branch_held", 8'(fdfl0), 0);
    advance();
    settle(); chk("lu_m1_fwd_b", 8'(fb0), 2); advance();
    settle(); chk("lu_m3_still", 8'(pc1), 0); advance();
    settle(); chk("lu_m3_fwd_b", 8'(fb1), 4); advance();

    // Load then dependent store
    drive(2, 7, 0, 0, 0, 0, 0, 0); settle(); advance();
    drive(3, 0, 1, 7, 1, 1, 0, 0); settle();
`ifdef HDU_STORE_FWD_EN
    chk("st_fwd_nostall", 8'(pc0), 1);
`else
    chk("st_stall", 8'(pc0), 0);
`endif
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0); settle();
`ifdef HDU_STORE_FWD_EN
    chk("st_fwd_ls", 8'(ls0), 1);
`else
    chk("st_ls_tied", 8'(ls0), 0);
`endif
    advance();
    settle(); advance();

    // x0 never forwards; youngest of two same-rd writers wins
    drive(1, 0, 0, 0, 0, 0, 0, 0); settle(); advance();
    drive(0, 0, 0, 0, 1, 1, 0, 0); settle();
    chk("x0_fwd_a", 8'(fa0), 0);
    advance();
    drive(1, 9, 0, 0, 0, 0, 0, 0); settle(); advance();
    drive(1, 9, 0, 0, 0, 0, 0, 0); settle(); advance();
    drive(0, 0, 9, 9, 1, 1, 0, 0); settle();
    chk("youngest_a", 8'(fa0), 1);
    chk("youngest_b", 8'(fb0), 1);
    advance();

    // Freeze during a load-use stall
    drive(2, 10, 0, 0, 0, 0, 0, 0); settle(); advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 10, 0, 1, 0, 1, 1); settle();
      chk("frz_fd_en", 8'(fden0), 0);
      chk("frz_fd_stall", 8'(fdst0), 0);
      chk("frz_de_flush", 8'(defl0), 0);
      advance();
    end
    drive(0, 0, 10, 0, 1, 0, 0, 0); settle();
    chk("frz_resume_stall", 8'(fdst0), 1);
    advance();

    // Reset in the middle of a stall
    drive(2, 11, 0, 0, 0, 0, 0, 0); settle(); advance();
    drive(0, 0, 11, 11, 1, 1, 0, 0); settle();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_pc_en", 8'(pc0), 1);
    chk("rst_fd_stall", 8'(fdst0), 0);
    chk("rst_fwd_b", 8'(fb1), 0);
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic on a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
      end else begin
        drive($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              ($urandom_range(0, 4) == 0) ? 1 : 0);
        settle();
        advance();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
